// File: rtl/lane_select_ctrl.sv
// lane_select_ctrl: debounced left/right buttons steer a one-hot aim across LANES lanes with auto-repeat
module lane_select_ctrl #(
  parameter int LANES = 3,
  parameter int OUT_W = 8,
  parameter int BASE = 1,
  parameter int STRIDE = 3,
  parameter int RST_LANE = 0,
  parameter int DEB_CYC = 4,
  parameter int REPEAT_DLY = 20,
  parameter int REPEAT_PER = 8,
  parameter int WRAP = 0,
  localparam int LW = LANES > 2 ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       ctl,
  output logic [OUT_W-1:0] aim,
  output logic [LW-1:0]    lane,
  output logic             moved,
  output logic             at_edge
);
  localparam int DW = DEB_CYC > 1 ? $clog2(DEB_CYC) : 1;
  localparam int RM = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
  localparam int RW = $clog2(RM + 1);
  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
  state_t state, nxt;
  logic [1:0] s1, s, cand, db, db_q;
  logic [DW-1:0] dc;
  logic [RW-1:0] rc, rc_nxt;
  logic step, single, chg;
  logic [LW-1:0] lane_up, lane_dn, lane_d;
  logic [OUT_W-1:0] aim_d;
  assign single = db == 2'b01 || db == 2'b10;
  assign chg = db != db_q;
  // a step always moves in the direction db currently holds
  assign lane_up = lane == LW'(LANES - 1) ? (WRAP != 0 ? '0 : lane) : lane + LW'(1);
  assign lane_dn = lane == '0 ? (WRAP != 0 ? LW'(LANES - 1) : lane) : lane - LW'(1);
  assign lane_d = step ? (db == 2'b01 ? lane_up : lane_dn) : lane;
  assign aim_d = OUT_W'(1) << (BASE + int'(lane_d) * STRIDE);
  always_comb begin
    nxt = state;
    rc_nxt = rc + RW'(1);
    step = 1'b0;
    if (!en) begin
      nxt = IDLE;
      rc_nxt = '0;
    end else if (state == IDLE) begin
      rc_nxt = '0;
      step = chg && single;
      nxt = chg && single ? HOLD : IDLE;
    end else if (chg) begin
      rc_nxt = '0;
      step = single;
      nxt = single ? HOLD : IDLE;
    end else if (state == HOLD && REPEAT_DLY != 0 && rc == RW'(REPEAT_DLY - 1)) begin
      rc_nxt = '0;
      step = 1'b1;
      nxt = RPT;
    end else if (state == RPT && rc == RW'(REPEAT_PER - 1)) begin
      rc_nxt = '0;
      step = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s <= '0;
      cand <= '0;
      db <= '0;
      db_q <= '0;
      dc <= '0;
      rc <= '0;
      state <= IDLE;
      lane <= LW'(RST_LANE);
      aim <= OUT_W'(1) << (BASE + RST_LANE * STRIDE);
      at_edge <= RST_LANE == 0 || RST_LANE == LANES - 1;
      moved <= 1'b0;
    end else begin
      s1 <= ctl;
      s <= s1;
      if (s != cand) begin
        cand <= s;
        dc <= '0;
      end else if (dc == DW'(DEB_CYC - 1)) begin
        db <= cand;
      end else begin
        dc <= dc + DW'(1);
      end
      db_q <= db;
      state <= nxt;
      rc <= rc_nxt;
      lane <= lane_d;
      aim <= aim_d;
      at_edge <= lane_d == '0 || lane_d == LW'(LANES - 1);
      moved <= lane_d != lane;
    end
  end
endmodule

// File: tb/tb_lane_select_ctrl.sv
// tb_lane_select_ctrl: four parameter variants driven by shared stimulus, checked against a window/age model
module tb_lane_select_ctrl;
  localparam int NI = 4;
  localparam int D = 4;
  localparam int HL = D + 3;
  localparam int P_LANES [NI] = '{3, 3, 8, 8};
  localparam int P_BASE [NI] = '{1, 1, 0, 0};
  localparam int P_STRIDE [NI] = '{3, 3, 1, 1};
  localparam int P_RST [NI] = '{0, 1, 0, 0};
  localparam int P_WRAP [NI] = '{0, 1, 0, 0};
  localparam int P_RD [NI] = '{20, 20, 20, 0};
  localparam int P_RP = 8;
  logic clk = 0, rst = 0, en = 1;
  logic [1:0] ctl = 2'b00;
  logic [7:0] aim_a [NI];
  logic [3:0] lane_a [NI];
  logic [NI-1:0] moved_a, edge_a;
  logic [1:0] lane0, lane1;
  logic [2:0] lane2, lane3;
  int total = 0, bad = 0;
  bit done = 0;
  always #5 clk = ~clk;
  assign lane_a[0] = 4'(lane0);
  assign lane_a[1] = 4'(lane1);
  assign lane_a[2] = 4'(lane2);
  assign lane_a[3] = 4'(lane3);
  lane_select_ctrl u0 (.clk(clk), .rst(rst), .en(en), .ctl(ctl), .aim(aim_a[0]), .lane(lane0), .moved(moved_a[0]), .at_edge(edge_a[0]));
  lane_select_ctrl #(.RST_LANE(1), .WRAP(1)) u1 (.clk(clk), .rst(rst), .en(en), .ctl(ctl), .aim(aim_a[1]), .lane(lane1), .moved(moved_a[1]), .at_edge(edge_a[1]));
  lane_select_ctrl #(.LANES(8), .BASE(0), .STRIDE(1)) u2 (.clk(clk), .rst(rst), .en(en), .ctl(ctl), .aim(aim_a[2]), .lane(lane2), .moved(moved_a[2]), .at_edge(edge_a[2]));
  lane_select_ctrl #(.LANES(8), .BASE(0), .STRIDE(1), .REPEAT_DLY(0)) u3 (.clk(clk), .rst(rst), .en(en), .ctl(ctl), .aim(aim_a[3]), .lane(lane3), .moved(moved_a[3]), .at_edge(edge_a[3]));
  // model: db takes the synchronised value once it has been seen D+1 times in a row;
  // moves happen on a fresh single-button press and then at fixed ages of that press
  logic [1:0] h [HL];
  logic [1:0] d = 0, dp = 0, dn;
  int edge_k = 0, age, nl;
  int m_lane [NI], press [NI];
  bit m_moved [NI], stable, mv;
  always @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < HL; j++) h[j] = 2'b00;
      d = 0;
      dp = 0;
      for (int i = 0; i < NI; i++) begin
        m_lane[i] = P_RST[i];
        press[i] = -1;
        m_moved[i] = 0;
      end
    end else begin
      edge_k++;
      for (int j = HL - 1; j > 0; j--) h[j] = h[j-1];
      h[0] = ctl;
      stable = 1;
      for (int j = 2; j < HL; j++) if (h[j] != h[2]) stable = 0;
      dn = stable ? h[2] : d;
      for (int i = 0; i < NI; i++) begin
        mv = 0;
        if (!en) press[i] = -1;
        else if (d != dp) begin
          if (d == 2'b01 || d == 2'b10) begin
            mv = 1;
            press[i] = edge_k;
          end else press[i] = -1;
        end else if (press[i] >= 0 && P_RD[i] != 0) begin
          age = edge_k - press[i];
          mv = age >= P_RD[i] && (age - P_RD[i]) % P_RP == 0;
        end
        nl = m_lane[i];
        if (mv && d == 2'b01) nl = m_lane[i] < P_LANES[i] - 1 ? m_lane[i] + 1 : (P_WRAP[i] != 0 ? 0 : m_lane[i]);
        if (mv && d == 2'b10) nl = m_lane[i] > 0 ? m_lane[i] - 1 : (P_WRAP[i] != 0 ? P_LANES[i] - 1 : m_lane[i]);
        m_moved[i] = nl != m_lane[i];
        m_lane[i] = nl;
      end
      dp = d;
      d = dn;
    end
  end
  task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", nm, i, $time, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic press_btn(logic [1:0] dir, int hold, int gap);
    ctl = dir;
    tick(hold);
    ctl = 2'b00;
    tick(gap);
  endtask
  initial begin
    fork
      begin
        tick(3);
        check("rst_aim", 0, 32'(aim_a[0]), 32'h02);
        check("rst_lane", 0, 32'(lane_a[0]), 0);
        check("rst_moved", 0, 32'(moved_a[0]), 0);
        check("rst_edge", 0, 32'(edge_a[0]), 1);
        check("rst_aim", 1, 32'(aim_a[1]), 32'h10);
        check("rst_lane", 1, 32'(lane_a[1]), 1);
        rst = 1;
        tick(10);
        ctl = 2'b01;
        tick(7);
        check("pre_move_aim", 0, 32'(aim_a[0]), 32'h02);
        tick(1);
        check("edge8_aim", 0, 32'(aim_a[0]), 32'h10);
        check("edge8_moved", 0, 32'(moved_a[0]), 1);
        check("edge8_lane", 1, 32'(lane_a[1]), 2);
        tick(1);
        check("pulse_len", 0, 32'(moved_a[0]), 0);
        tick(1);
        ctl = 2'b00;
        tick(15);
        press_btn(2'b01, 10, 15);
        check("second_aim", 0, 32'(aim_a[0]), 32'h80);
        check("wrap_up_aim", 1, 32'(aim_a[1]), 32'h02);
        check("wrap_up_lane", 1, 32'(lane_a[1]), 0);
        press_btn(2'b01, 10, 15);
        check("sat_aim", 0, 32'(aim_a[0]), 32'h80);
        press_btn(2'b10, 10, 15);
        press_btn(2'b10, 10, 15);
        check("wrap_dn_lane", 1, 32'(lane_a[1]), 2);
        check("down_lane", 0, 32'(lane_a[0]), 0);
        press_btn(2'b01, 3, 15);
        check("glitch_lane", 0, 32'(lane_a[0]), 0);
        press_btn(2'b11, 50, 15);
        check("both_aim", 0, 32'(aim_a[0]), 32'h02);
        rst = 0;
        tick(2);
        rst = 1;
        tick(5);
        press_btn(2'b01, 60, 20);
        check("repeat_lane", 2, 32'(lane_a[2]), 6);
        check("norepeat_lane", 3, 32'(lane_a[3]), 1);
        check("repeat_sat", 0, 32'(lane_a[0]), 2);
        en = 0;
        press_btn(2'b01, 10, 15);
        check("en_off_lane", 2, 32'(lane_a[2]), 6);
        ctl = 2'b01;
        tick(12);
        en = 1;
        tick(30);
        ctl = 2'b00;
        tick(15);
        check("en_reassert", 2, 32'(lane_a[2]), 6);
        rst = 0;
        tick(1);
        rst = 1;
        tick(3);
        ctl = 2'b01;
        tick(40);
        check("rpt_lane", 2, 32'(lane_a[2]), 3);
        rst = 0;
        #1;
        check("async_lane", 2, 32'(lane_a[2]), 0);
        check("async_aim", 2, 32'(aim_a[2]), 32'h01);
        check("async_moved", 2, 32'(moved_a[2]), 0);
        check("async_aim", 0, 32'(aim_a[0]), 32'h02);
        tick(2);
        rst = 1;
        tick(15);
        ctl = 2'b00;
        tick(20);
        check("held_thru_rst", 2, 32'(lane_a[2]), 1);
        check("held_thru_rst", 3, 32'(lane_a[3]), 1);
        done = 1;
      end
      begin
        @(posedge clk);
        while (!done) begin
          @(negedge clk);
          for (int i = 0; i < NI; i++) begin
            check("m_lane", i, 32'(lane_a[i]), 32'(m_lane[i]));
            check("m_aim", i, 32'(aim_a[i]), 32'(8'(1) << (P_BASE[i] + m_lane[i] * P_STRIDE[i])));
            check("m_moved", i, 32'(moved_a[i]), 32'(m_moved[i]));
            check("m_edge", i, 32'(edge_a[i]), 32'(m_lane[i] == 0 || m_lane[i] == P_LANES[i] - 1));
          end
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
